qsys_pio_edge_in: RTL and testbench
===================================

// Module: qsys_pio_edge_in
// PURPOSE
//  Avalon-MM slave input PIO: the read-side counterpart of the LED/output PIOs in the Qsys system.
//  Samples an external input bus (keys/switches) through a synchronizer, latches selected edges
//  into a sticky edge-capture register, and raises a maskable level interrupt to the Nios II.
//  Sits on the Qsys data master fabric; zero-wait-state, read latency 0.
// PARAMETERS
//  WIDTH        4   width of in_port, 1..32
//  SYNC_STAGES  2   synchronizer depth on in_port, 2..4
//  EDGE_TYPE    0   0 = rising, 1 = falling, 2 = any edge captured
// PORTS
//  clk         in   1      system clock; the only clock
//  reset       in   1      asynchronous, active-high reset
//  address     in   2      register word select
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe, qualified by chipselect
//  writedata   in   32     write data
//  readdata    out  32     read data, combinational from address, upper bits 0
//  in_port     in   WIDTH  asynchronous external inputs
//  irq         out  1      level interrupt, active-high
// BEHAVIOUR
//  Register map (word address):
//   0 DATA     RO  synchronized in_port; writes ignored
//   1 (none)   RO  reads 0; writes ignored
//   2 IRQMASK  RW  bit i enables irq for edge_capture[i]
//   3 EDGECAP  R/W1C  sticky edge flags; writing 1 to bit i clears it, 0 leaves it unchanged
//  Write accepted when chipselect && !write_n; writedata[WIDTH-1:0] used, upper bits ignored.
//  readdata = {zeros, selected register}; no chipselect gating on read mux; no wait states.
//  Input path: in_port -> SYNC_STAGES flops (sync_q) -> one delay flop (prev_q).
//   DATA reads sync_q. Latency from in_port change to DATA visible = SYNC_STAGES clocks.
//  Edge detect per bit: rise = sync_q & ~prev_q; fall = ~sync_q & prev_q; per EDGE_TYPE.
//  Arming: after reset, a small counter holds detection disabled for SYNC_STAGES+1 clocks
//   so an input already high/low at reset release raises no spurious edge; thereafter armed.
//  edge_capture[i] next = edge_i | (edge_capture[i] & ~clr_i), clr_i = EDGECAP write with bit i=1.
//   Simultaneous edge and clear on same bit: edge wins, bit stays 1.
//   Repeated edges while set: remains 1 (no count, no overflow).
//  irq = |(edge_capture & irq_mask), combinational from flops; deasserts the cycle after a
//   clear or mask write takes effect (i.e. same cycle the register updates).
//  Reset (any time, incl. mid-transfer): sync_q, prev_q, irq_mask, edge_capture = 0,
//   arm counter = 0 (disarmed), irq = 0, readdata follows address (DATA reads 0).
//  Edge pulse narrower than one clk may be missed; no guarantee below 2 clk periods.
// STRUCTURE
//  Package qsys_pio_pkg: address constants (PIO_ADDR_DATA=0, PIO_ADDR_MASK=2, PIO_ADDR_EDGE=3),
//   edge-type encodings (PIO_EDGE_RISE/FALL/ANY), shared with output PIO blocks.
//  Sub-module pio_in_sync: WIDTH x SYNC_STAGES async-reset synchronizer chain; instantiated once.
//  Top holds arm counter, prev_q, edge logic, mask/capture regs, read mux, irq.
// TESTING
//  1 Reset with in_port=4'hF held, release -> no edge captured, EDGECAP reads 0, irq=0;
//    DATA reads 4'hF after SYNC_STAGES+1 clocks.
//  2 EDGE_TYPE=0, IRQMASK=4'h1, pulse in_port[0] 0->1 for 3 clk -> EDGECAP=1, irq=1
//    exactly SYNC_STAGES+1 clocks after the in_port edge; falling edge adds nothing.
//  3 EDGECAP=4'h5, write 4'h1 to addr 3 -> EDGECAP=4'h4 next cycle; irq drops if mask=4'h1.
//  4 Clear write to bit 2 in same cycle as new bit-2 edge -> bit 2 remains 1, irq stays.
//  5 EDGE_TYPE=2, toggle in_port[3] twice, IRQMASK=0 -> EDGECAP=4'h8, irq=0; write
//    IRQMASK=4'h8 -> irq=1 next cycle; read addr 1 -> 0; write addr 0 -> DATA unchanged.
//  6 Assert reset mid-sequence with EDGECAP=4'hF, mask=4'hF -> irq=0, all regs 0 while reset
//    high; after release, re-arm delay honoured before any new capture.

Source files
------------

// File: rtl/qsys_pio_pkg.sv
// Shared definitions for the Qsys PIO blocks: register word addresses and
// edge-capture type encodings.
package qsys_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_NONE = 2'd1;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  localparam int PIO_EDGE_RISE = 0;
  localparam int PIO_EDGE_FALL = 1;
  localparam int PIO_EDGE_ANY  = 2;

  // Picks the edge events that count for a given edge type; unknown types fall back to rising.
  function automatic logic [31:0] pio_edge_sel(input logic [31:0] rise,
                                               input logic [31:0] fall,
                                               input int          edge_type);
    logic [31:0] sel;
    case (edge_type)
      PIO_EDGE_RISE: sel = rise;
      PIO_EDGE_FALL: sel = fall;
      PIO_EDGE_ANY:  sel = rise | fall;
      default:       sel = rise;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/pio_in_sync.sv
// Multi-stage synchronizer for the asynchronous PIO input bus.
module pio_in_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [STAGES-1:0][WIDTH-1:0] sync_d;

  // Shift the raw input one stage deeper each clock.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchronizer flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/qsys_pio_edge_in.sv
// Avalon-MM input PIO: synchronized data register, sticky edge capture with
// write-1-to-clear, and a maskable level interrupt.
module qsys_pio_edge_in
  import qsys_pio_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_MAX + 1);

  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [ARM_W-1:0] arm_q, arm_d;
  logic             armed_s;
  logic             wr_en_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] edge_s;
  logic [31:0]      edge_all_s;
  logic [WIDTH-1:0] rd_sel_s;
  logic             unused_s;

  pio_in_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_port),
    .q     (sync_s)
  );

  assign wr_en_s  = chipselect & ~write_n;
  assign armed_s  = (arm_q == ARM_W'(ARM_MAX));
  assign unused_s = ^{writedata, edge_all_s};

  // Next-state for arm counter, delay flop, mask and sticky capture.
  always_comb begin
    arm_d          = arm_q;
    prev_d         = sync_s;
    irq_mask_d     = irq_mask_q;
    clr_s          = '0;
    edge_all_s     = pio_edge_sel(32'(sync_s & ~prev_q), 32'(~sync_s & prev_q), EDGE_TYPE);
    edge_s         = '0;
    // Detection stays off until the synchronizer and delay flop hold real input data.
    if (!armed_s) begin
      arm_d = arm_q + ARM_W'(1);
    end else begin
      edge_s = edge_all_s[WIDTH-1:0];
    end
    if (wr_en_s && (address == PIO_ADDR_MASK)) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end else begin
      irq_mask_d = irq_mask_q;
    end
    if (wr_en_s && (address == PIO_ADDR_EDGE)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = '0;
    end
    edge_capture_d = edge_s | (edge_capture_q & ~clr_s);
  end

  // Register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_q          <= '0;
      prev_q         <= '0;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
    end else begin
      arm_q          <= arm_d;
      prev_q         <= prev_d;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
    end
  end

  // Zero-latency read mux, zero-extended to the bus width.
  always_comb begin
    case (address)
      PIO_ADDR_DATA: rd_sel_s = sync_s;
      PIO_ADDR_MASK: rd_sel_s = irq_mask_q;
      PIO_ADDR_EDGE: rd_sel_s = edge_capture_q;
      default:       rd_sel_s = '0;
    endcase
    readdata              = 32'd0;
    readdata[WIDTH-1:0]   = rd_sel_s;
  end

  assign irq = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_qsys_pio_edge_in.sv
// Self-checking bench: rising-edge and any-edge PIO instances on a shared bus,
// checked every cycle against an input-history model plus directed literals.
module tb_qsys_pio_edge_in;

  localparam int W = 4;
  localparam int N = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        cs;
  logic        wn;
  logic [31:0] wd;
  logic [3:0]  in_port;
  logic [31:0] rd_r, rd_a;
  logic        irq_r, irq_a;

  int checks   = 0;
  int failures = 0;

  qsys_pio_edge_in #(.WIDTH(W), .SYNC_STAGES(N), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs), .write_n(wn),
    .writedata(wd), .readdata(rd_r), .in_port(in_port), .irq(irq_r));

  qsys_pio_edge_in #(.WIDTH(W), .SYNC_STAGES(N), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs), .write_n(wn),
    .writedata(wd), .readdata(rd_a), .in_port(in_port), .irq(irq_a));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: in_port value sampled at each clock since reset release, plus mask/capture.
  logic [3:0] hq[$];
  logic [3:0] m_cap_r, m_cap_a, m_mask;

  function automatic logic [3:0] hist(input int off);
    int c;
    c = hq.size();
    if (c - off >= 1) return hq[c - off - 1];
    return 4'h0;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] cap);
    case (address)
      2'd0:    return {28'd0, hist(N - 1)};
      2'd2:    return {28'd0, m_mask};
      2'd3:    return {28'd0, cap};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [3:0] s, p, rise, fall, clr;
    bit armed;
    if (reset) begin
      hq.delete();
      m_cap_r = 4'h0;
      m_cap_a = 4'h0;
      m_mask  = 4'h0;
    end else begin
      s     = hist(N - 1);
      p     = hist(N);
      armed = (hq.size() >= N + 1);
      rise  = armed ? (s & ~p) : 4'h0;
      fall  = armed ? (~s & p) : 4'h0;
      clr   = (cs && !wn && address == 2'd3) ? wd[3:0] : 4'h0;
      m_cap_r = rise | (m_cap_r & ~clr);
      m_cap_a = rise | fall | (m_cap_a & ~clr);
      if (cs && !wn && address == 2'd2) m_mask = wd[3:0];
      hq.push_back(in_port);
    end
  end

  always @(posedge clk) begin
    #1;
    check("model_rd_rise", rd_r, m_read(m_cap_r));
    check("model_rd_any", rd_a, m_read(m_cap_a));
    check("model_irq_rise", {31'd0, irq_r}, {31'd0, |(m_cap_r & m_mask)});
    check("model_irq_any", {31'd0, irq_a}, {31'd0, |(m_cap_a & m_mask)});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(input logic [3:0] v);
    @(negedge clk);
    in_port = v;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; wn = 1'b0; address = a; wd = d;
    @(negedge clk);
    cs = 1'b0; wn = 1'b1; wd = 32'd0;
  endtask

  task automatic peek(input string name, input logic [1:0] a,
                      input logic [31:0] exp_r, input logic [31:0] exp_a);
    @(negedge clk);
    address = a;
    #1;
    check({name, "_rise"}, rd_r, exp_r);
    check({name, "_any"}, rd_a, exp_a);
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; wn = 1'b1; address = 2'd0; wd = 32'd0; in_port = 4'hF;

    // 1: reset with inputs high, no spurious capture after release
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", rd_r, 32'd0);
    check("rst_irq", {31'd0, irq_r}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick(6);
    peek("t1_edgecap", 2'd3, 32'h0, 32'h0);
    peek("t1_data", 2'd0, 32'hF, 32'hF);
    check("t1_irq", {30'd0, irq_r, irq_a}, 32'd0);

    set_in(4'h0);
    tick(5);
    bus_wr(2'd3, 32'hF);
    bus_wr(2'd2, 32'h1);
    peek("t2_pre", 2'd3, 32'h0, 32'h0);

    // 2: rising pulse on bit 0, irq exactly SYNC_STAGES+1 clocks later
    @(negedge clk);
    in_port = 4'h1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("t2_irq_early", {31'd0, irq_r}, 32'd0);
    @(posedge clk);
    #1;
    check("t2_irq_on_time", {31'd0, irq_r}, 32'd1);
    set_in(4'h0);
    tick(5);
    peek("t2_edgecap", 2'd3, 32'h1, 32'h1);
    check("t2_irq_after_fall", {31'd0, irq_r}, 32'd1);

    // 3: W1C of bit 0 from 4'h5
    set_in(4'h4);
    tick(2);
    set_in(4'h0);
    tick(5);
    peek("t3_pre", 2'd3, 32'h5, 32'h5);
    bus_wr(2'd3, 32'h1);
    check("t3_irq_drop", {31'd0, irq_r}, 32'd0);
    peek("t3_edgecap", 2'd3, 32'h4, 32'h4);

    // 4: clear and new edge on bit 2 in the same cycle
    bus_wr(2'd2, 32'h4);
    bus_wr(2'd3, 32'h4);
    check("t4_cleared_irq", {31'd0, irq_r}, 32'd0);
    @(negedge clk);
    in_port = 4'h4;
    @(negedge clk);
    @(negedge clk);
    cs = 1'b1; wn = 1'b0; address = 2'd3; wd = 32'h4;
    @(negedge clk);
    cs = 1'b0; wn = 1'b1; wd = 32'd0;
    #1;
    check("t4_edge_wins", rd_r, 32'h4);
    check("t4_irq", {31'd0, irq_r}, 32'd1);
    set_in(4'h0);
    tick(5);

    // 5: any-edge capture, mask enable, unmapped read, DATA write ignored
    bus_wr(2'd3, 32'hF);
    bus_wr(2'd2, 32'h0);
    set_in(4'h8);
    tick(2);
    set_in(4'h0);
    tick(7);
    peek("t5_edgecap", 2'd3, 32'h8, 32'h8);
    check("t5_irq_masked", {31'd0, irq_a}, 32'd0);
    bus_wr(2'd2, 32'h8);
    check("t5_irq_unmasked", {31'd0, irq_a}, 32'd1);
    peek("t5_addr1", 2'd1, 32'h0, 32'h0);
    bus_wr(2'd0, 32'hF);
    peek("t5_data", 2'd0, 32'h0, 32'h0);

    // 6: reset mid-sequence with everything set, then re-arm
    set_in(4'hF);
    tick(2);
    set_in(4'h0);
    tick(5);
    bus_wr(2'd2, 32'hF);
    peek("t6_pre", 2'd3, 32'hF, 32'hF);
    check("t6_irq_pre", {30'd0, irq_r, irq_a}, 32'h3);
    set_in(4'hF);
    tick(3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_rst_irq", {30'd0, irq_r, irq_a}, 32'd0);
    check("t6_rst_edgecap", rd_r, 32'h0);
    address = 2'd2;
    #1;
    check("t6_rst_mask", rd_a, 32'h0);
    address = 2'd0;
    #1;
    check("t6_rst_data", rd_r, 32'h0);
    tick(2);
    reset = 1'b0;
    tick(8);
    peek("t6_rearm_edgecap", 2'd3, 32'h0, 32'h0);
    peek("t6_rearm_data", 2'd0, 32'hF, 32'hF);
    set_in(4'h0);
    tick(5);
    peek("t6_fall_after_rearm", 2'd3, 32'h0, 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
